// File: rtl/abr_loop_seq.sv
// Hardened two-level (outer, inner) loop index sequencer built from two cross-checked counters.
// Optional macro ABR_LOOP_SEQ_BUBBLE_EN inserts one idle cycle after every outer-index advance.

// Cross-checked up counter: the primary counts up and the secondary counts down from all-ones,
// so pri == ~sec always holds. Saturation or any divergence between the two raises err_o.
module abr_hard_cnt #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_b,
  input  logic             clr_i,
  input  logic             incr_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] pri_q, pri_d;
  logic [Width-1:0] sec_q, sec_d;
  logic             sat_q, sat_d;
  logic [Width:0]   up_sum;
  logic [Width:0]   dn_diff;

  // NOTE: every signal written in an always_comb gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    up_sum  = {1'b0, pri_q} + {1'b0, step_i};
    dn_diff = {1'b0, sec_q} - {1'b0, step_i};
    pri_d   = pri_q;
    sec_d   = sec_q;
    sat_d   = sat_q;
    if (clr_i) begin
      pri_d = '0;
      sec_d = '1;
    end else if (incr_i) begin
      pri_d = up_sum[Width]  ? '1 : up_sum[Width-1:0];
      sec_d = dn_diff[Width] ? '0 : dn_diff[Width-1:0];
      sat_d = sat_q | up_sum[Width] | dn_diff[Width];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      pri_q <= '0;
      sec_q <= '1;
      sat_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
      sec_q <= sec_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = pri_q;
  assign err_o = sat_q | (pri_q != ~sec_q);

endmodule

module abr_loop_seq #(
  parameter int OuterWidth = 4,
  parameter int InnerWidth = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_b,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [OuterWidth-1:0] outer_max_i,
  input  logic [InnerWidth-1:0] inner_max_i,
  input  logic [InnerWidth-1:0] inner_step_i,
  input  logic                  stall_i,
  output logic                  valid_o,
  output logic [OuterWidth-1:0] outer_idx_o,
  output logic [InnerWidth-1:0] inner_idx_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Sparse encoding, pairwise Hamming distance >= 3; any other value falls into ERROR.
  typedef enum logic [5:0] {
    StIdle   = 6'b001011,
    StRun    = 6'b010110,
`ifdef ABR_LOOP_SEQ_BUBBLE_EN
    StBubble = 6'b100101,
`endif
    StDone   = 6'b111000,
    StError  = 6'b111111
  } state_e;

  state_e                state_q, state_d;
  logic [OuterWidth-1:0] outer_max_q;
  logic [InnerWidth-1:0] inner_max_q;
  logic [InnerWidth-1:0] step_q;
  logic [OuterWidth-1:0] outer_idx;
  logic [InnerWidth-1:0] inner_idx;
  logic [InnerWidth:0]   inner_sum;
  logic                  inner_clr, inner_incr, outer_clr, outer_incr, cfg_load;
  logic                  inner_err, outer_err;
  logic                  wrap, outer_last, accept;

  abr_hard_cnt #(.Width(InnerWidth)) u_inner_cnt (
    .clk_i  (clk_i),
    .rst_b  (rst_b),
    .clr_i  (inner_clr),
    .incr_i (inner_incr),
    .step_i (step_q),
    .cnt_o  (inner_idx),
    .err_o  (inner_err)
  );

  abr_hard_cnt #(.Width(OuterWidth)) u_outer_cnt (
    .clk_i  (clk_i),
    .rst_b  (rst_b),
    .clr_i  (outer_clr),
    .incr_i (outer_incr),
    .step_i (OuterWidth'(1)),
    .cnt_o  (outer_idx),
    .err_o  (outer_err)
  );

  // One extra bit so idx + step cannot alias below the bound.
  assign inner_sum  = {1'b0, inner_idx} + {1'b0, step_q};
  assign wrap       = inner_sum > {1'b0, inner_max_q};
  assign outer_last = outer_idx == outer_max_q;
  assign accept     = valid_o & ~stall_i;

  always_comb begin
    state_d    = state_q;
    inner_clr  = 1'b0;
    inner_incr = 1'b0;
    outer_clr  = 1'b0;
    outer_incr = 1'b0;
    cfg_load   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (inner_step_i == '0) begin
            state_d = StError;
          end else begin
            cfg_load  = 1'b1;
            inner_clr = 1'b1;
            outer_clr = 1'b1;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          inner_clr = 1'b1;
          outer_clr = 1'b1;
          state_d   = StIdle;
        end else if (accept) begin
          if (!wrap) begin
            inner_incr = 1'b1;
          end else if (!outer_last) begin
            inner_clr  = 1'b1;
            outer_incr = 1'b1;
`ifdef ABR_LOOP_SEQ_BUBBLE_EN
            state_d    = StBubble;
`else
            state_d    = StRun;
`endif
          end else begin
            state_d = StDone;
          end
        end
      end
`ifdef ABR_LOOP_SEQ_BUBBLE_EN
      StBubble: begin
        if (abort_i) begin
          inner_clr = 1'b1;
          outer_clr = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StRun;
        end
      end
`endif
      StDone: begin
        if (abort_i) begin
          inner_clr = 1'b1;
          outer_clr = 1'b1;
        end
        state_d = StIdle;
      end
      StError: state_d = StError;
      default: state_d = StError;
    endcase
    // Counter integrity failures override every other transition.
    if (inner_err || outer_err) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      outer_max_q <= '0;
      inner_max_q <= '0;
      step_q      <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        outer_max_q <= outer_max_i;
        inner_max_q <= inner_max_i;
        step_q      <= inner_step_i;
      end
    end
  end

  assign valid_o     = state_q == StRun;
  assign last_o      = valid_o & wrap & outer_last;
  assign busy_o      = state_q != StIdle;
  assign done_o      = (state_q == StDone) & ~abort_i;
  assign err_o       = state_q == StError;
  assign outer_idx_o = outer_idx;
  assign inner_idx_o = inner_idx;

endmodule

// File: tb/tb_abr_loop_seq.sv
// Self-checking bench for abr_loop_seq: a per-cycle expected timeline is built from the loop
// rules (beat lists, stalls, bubbles, done/abort) and compared against the DUT every cycle.
module tb_abr_loop_seq;

  localparam int OW = 4;
  localparam int IW = 6;

  logic          clk_i = 1'b0;
  logic          rst_b = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [OW-1:0] outer_max_i = '0;
  logic [IW-1:0] inner_max_i = '0;
  logic [IW-1:0] inner_step_i = '0;
  logic          stall_i = 1'b0;
  logic          valid_o;
  logic [OW-1:0] outer_idx_o;
  logic [IW-1:0] inner_idx_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  abr_loop_seq #(.OuterWidth(OW), .InnerWidth(IW)) dut (
    .clk_i        (clk_i),
    .rst_b        (rst_b),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .outer_max_i  (outer_max_i),
    .inner_max_i  (inner_max_i),
    .inner_step_i (inner_step_i),
    .stall_i      (stall_i),
    .valid_o      (valid_o),
    .outer_idx_o  (outer_idx_o),
    .inner_idx_o  (inner_idx_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit start, abort, stall;
    bit valid, last, busy, done, err, chk_idx;
    int outer, inner;
  } ent_t;

  ent_t          tl[$];
  ent_t          exp_e;
  bit            chk_en = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            dut_beats, done_seen, valid_cycles, busy_cycles;
  logic [IW-1:0] flip_val;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Compare process: mid-cycle, away from the rising edge.
  always @(negedge clk_i) begin
    #2;
    if (chk_en) begin
      check("valid", int'(valid_o), int'(exp_e.valid));
      check("last",  int'(last_o),  int'(exp_e.last));
      check("busy",  int'(busy_o),  int'(exp_e.busy));
      check("done",  int'(done_o),  int'(exp_e.done));
      check("err",   int'(err_o),   int'(exp_e.err));
      if (exp_e.chk_idx) begin
        check("outer_idx", int'(outer_idx_o), exp_e.outer);
        check("inner_idx", int'(inner_idx_o), exp_e.inner);
      end
      if (valid_o && !stall_i) dut_beats++;
      if (done_o)  done_seen++;
      if (valid_o) valid_cycles++;
      if (busy_o)  busy_cycles++;
    end
  end

  function automatic ent_t blank();
    ent_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one nest, derived from the loop-walk rules.
  task automatic build_nest(input int om, input int im, input int st, input int stall_beat,
                            input int stall_len, input int abort_beat, input bit start_in_run);
    ent_t e;
    int   b = 0;
    int   last_i = 0;
    bit   last;
    outer_max_i  = OW'(om);
    inner_max_i  = IW'(im);
    inner_step_i = IW'(st);
    e = blank();
    e.start = 1'b1;
    tl.push_back(e);
    for (int o = 0; o <= om; o++) begin
      for (int i = 0; i <= im; i += st) begin
        last = (o == om) && (i + st > im);
        e = blank();
        e.valid = 1'b1; e.busy = 1'b1; e.chk_idx = 1'b1; e.last = last;
        e.outer = o; e.inner = i; e.start = start_in_run;
        if (b == stall_beat) begin
          e.stall = 1'b1;
          repeat (stall_len) tl.push_back(e);
        end
        e.stall = 1'b0;
        e.abort = (b == abort_beat);
        tl.push_back(e);
        if (e.abort) begin
          e = blank();
          e.chk_idx = 1'b1;
          tl.push_back(e);
          return;
        end
        b++;
        last_i = i;
`ifdef ABR_LOOP_SEQ_BUBBLE_EN
        if (i + st > im && !last) begin
          e = blank();
          e.busy = 1'b1; e.chk_idx = 1'b1; e.outer = o + 1; e.inner = 0;
          tl.push_back(e);
        end
`endif
      end
    end
    e = blank();
    e.busy = 1'b1; e.done = 1'b1; e.chk_idx = 1'b1; e.outer = om; e.inner = last_i;
    tl.push_back(e);
    tl.push_back(blank());
  endtask

  task automatic clear_stats();
    dut_beats = 0; done_seen = 0; valid_cycles = 0; busy_cycles = 0;
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n && k < tl.size(); k++) begin
      @(negedge clk_i);
      start_i = tl[k].start;
      abort_i = tl[k].abort;
      stall_i = tl[k].stall;
      exp_e   = tl[k];
      chk_en  = 1'b1;
    end
  endtask

  task automatic quiesce();
    @(negedge clk_i);
    chk_en  = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    stall_i = 1'b0;
    tl.delete();
  endtask

  task automatic play_all();
    play(tl.size());
    quiesce();
  endtask

  task automatic do_reset(input string tag);
    quiesce();
    rst_b = 1'b0;
    #2;
    check({tag, "_valid"}, int'(valid_o), 0);
    check({tag, "_last"},  int'(last_o),  0);
    check({tag, "_busy"},  int'(busy_o),  0);
    check({tag, "_done"},  int'(done_o),  0);
    check({tag, "_err"},   int'(err_o),   0);
    check({tag, "_outer"}, int'(outer_idx_o), 0);
    check({tag, "_inner"}, int'(inner_idx_o), 0);
    @(negedge clk_i);
    rst_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    do_reset("reset");

    // Full 2x4 walk, no stall: 8 beats, one done.
    clear_stats();
    build_nest(1, 3, 1, -1, 0, -1, 1'b0);
    play_all();
    check("a_beats", dut_beats, 8);
    check("a_done", done_seen, 1);

    // Step 4 over 0..6: beats (0,0),(0,4); second beat stalled 3 cycles.
    clear_stats();
    build_nest(0, 6, 4, 1, 3, -1, 1'b0);
    play_all();
    check("b_beats", dut_beats, 2);
    check("b_valid_cycles", valid_cycles, 5);
    check("b_done", done_seen, 1);

    // Three outer rows of one beat; start_i held during the run must be ignored.
    clear_stats();
    build_nest(2, 0, 1, -1, 0, -1, 1'b1);
    play_all();
    check("c_valid_cycles", valid_cycles, 3);
    check("c_done", done_seen, 1);
`ifdef ABR_LOOP_SEQ_BUBBLE_EN
    check("c_busy_cycles", busy_cycles, 6);
`else
    check("c_busy_cycles", busy_cycles, 4);
`endif

    // Abort together with the accepted last beat: no done, indices cleared.
    clear_stats();
    build_nest(0, 1, 1, -1, 0, 1, 1'b0);
    play_all();
    check("d_beats", dut_beats, 2);
    check("d_done", done_seen, 0);

    // Uneven step: 0..5 by 2 over two rows -> 6 beats.
    clear_stats();
    build_nest(1, 5, 2, 2, 1, -1, 1'b0);
    play_all();
    check("e_beats", dut_beats, 6);

    // Reset in the middle of a run.
    build_nest(1, 3, 1, -1, 0, -1, 1'b0);
    play(4);
    do_reset("midrun_reset");

    // Zero step: ERROR next cycle; start/abort afterwards ignored until reset.
    outer_max_i = 4'd1; inner_max_i = 6'd3; inner_step_i = 6'd0;
    e = blank(); e.start = 1'b1;
    tl.push_back(e);
    for (int k = 0; k < 4; k++) begin
      e = blank();
      e.err = 1'b1; e.busy = 1'b1;
      e.start = k[0]; e.abort = ~k[0];
      tl.push_back(e);
    end
    inner_step_i = 6'd0;
    play_all();
    inner_step_i = 6'd1;
    do_reset("zstep_reset");

    // Flip one bit of the inner secondary counter during a run.
    build_nest(3, 7, 1, -1, 0, -1, 1'b0);
    play(6);
    quiesce();
    flip_val = dut.u_inner_cnt.sec_q ^ 6'd1;
    force dut.u_inner_cnt.sec_q = flip_val;
    #2;
    check("flt_valid_pre", int'(valid_o), 1);
    check("flt_err_pre", int'(err_o), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      start_i = 1'b1;
      abort_i = 1'b1;
      #2;
      check("flt_err", int'(err_o), 1);
      check("flt_valid", int'(valid_o), 0);
      check("flt_busy", int'(busy_o), 1);
      check("flt_done", int'(done_o), 0);
    end
    release dut.u_inner_cnt.sec_q;
    do_reset("flt_reset");

    // After recovery a normal nest runs again.
    clear_stats();
    build_nest(0, 2, 1, -1, 0, -1, 1'b0);
    play_all();
    check("g_beats", dut_beats, 3);
    check("g_done", done_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
